// File: rtl/snake_body_engine_if.sv
// snake_body_engine_if: tick, direction, food and query inputs plus
// head, length and status outputs of the snake body engine.
interface snake_body_engine_if #(
  parameter int CW = 6
);
  logic          step;
  logic [2:0]    state;
  logic [CW-1:0] food_x;
  logic [CW-1:0] food_y;
  logic [CW-1:0] query_x;
  logic [CW-1:0] query_y;
  logic [CW-1:0] head_x;
  logic [CW-1:0] head_y;
  logic [4:0]    length;
  logic          ate;
  logic          X;
  logic          busy;
  logic          query_hit;

  modport master (
    output step, state, food_x, food_y,
    output query_x, query_y,
    input  head_x, head_y, length, ate,
    input  X, busy, query_hit
  );

  modport slave (
    input  step, state, food_x, food_y,
    input  query_x, query_y,
    output head_x, head_y, length, ate,
    output X, busy, query_hit
  );
endinterface

// File: rtl/snake_body_engine.sv
// snake_body_engine: moves the head per tick, shifts/grows the body,
// flags wall/self collisions. Toroidal grid when SNAKE_WRAP_EN is defined.
module snake_body_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int CW       = 6
) (
  input  logic clkFSM,
  input  logic reset,
  snake_body_engine_if.slave bus
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0]    LMAX = 5'(MAX_LEN);
  localparam logic [CW-1:0] XMAX = CW'(GRID_W - 1);
  localparam logic [CW-1:0] YMAX = CW'(GRID_H - 1);

  typedef enum logic [2:0] {
    IDLE, CALC, CHECK, COMMIT, DEAD
  } fsm_t;

  fsm_t          fsm;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  logic [4:0]    len;
  logic [4:0]    lim;
  logic [4:0]    idx;
  logic [CW-1:0] nx_r;
  logic [CW-1:0] ny_r;
  logic          eat_r;
  logic          ate_r;
  logic          x_r;
  logic          busy_r;
  logic          qhit_r;

  logic [CW-1:0] hx;
  logic [CW-1:0] hy;
  logic [CW-1:0] nx;
  logic [CW-1:0] ny;
  logic          oob;
  logic          dir_ok;
  logic          eat;
  logic          qhit;
  logic          hit;
  logic [IW-1:0] ci;

  assign hx  = seg_x[0];
  assign hy  = seg_y[0];
  assign ci  = idx[IW-1:0];
  assign hit = (seg_x[ci] == nx_r) &&
               (seg_y[ci] == ny_r);
  assign eat = (nx == bus.food_x) &&
               (ny == bus.food_y);

  assign bus.head_x    = hx;
  assign bus.head_y    = hy;
  assign bus.length    = len;
  assign bus.ate       = ate_r;
  assign bus.X         = x_r;
  assign bus.busy      = busy_r;
  assign bus.query_hit = qhit_r;

  // Next head cell from the live direction code; oob marks a wall exit.
  always_comb begin
    nx     = hx;
    ny     = hy;
    oob    = 1'b0;
    dir_ok = 1'b1;
    unique case (1'b1)
      (bus.state == 3'd1): begin
`ifdef SNAKE_WRAP_EN
        ny = (hy == '0) ? YMAX : hy - 1'b1;
`else
        oob = (hy == '0);
        ny  = hy - 1'b1;
`endif
      end
      (bus.state == 3'd2): begin
`ifdef SNAKE_WRAP_EN
        ny = (hy >= YMAX) ? '0 : hy + 1'b1;
`else
        oob = (hy >= YMAX);
        ny  = hy + 1'b1;
`endif
      end
      (bus.state == 3'd3): begin
`ifdef SNAKE_WRAP_EN
        nx = (hx == '0) ? XMAX : hx - 1'b1;
`else
        oob = (hx == '0);
        nx  = hx - 1'b1;
`endif
      end
      (bus.state == 3'd4): begin
`ifdef SNAKE_WRAP_EN
        nx = (hx >= XMAX) ? '0 : hx + 1'b1;
`else
        oob = (hx >= XMAX);
        nx  = hx + 1'b1;
`endif
      end
      default: dir_ok = 1'b0;
    endcase
  end

  // Parallel occupancy compare of the query cell over live segments.
  always_comb begin
    qhit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((5'(k) < len) &&
          (seg_x[k] == bus.query_x) &&
          (seg_y[k] == bus.query_y)) begin
        qhit = 1'b1;
      end
    end
  end

  // Move sequencer: calc, serial self-check, commit; DEAD is terminal.
  always_ff @(posedge clkFSM or posedge reset) begin
    if (reset) begin
      fsm    <= IDLE;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= CW'(GRID_W / 2 - k);
        seg_y[k] <= CW'(GRID_H / 2);
      end
      len    <= 5'(INIT_LEN);
      lim    <= '0;
      idx    <= '0;
      nx_r   <= '0;
      ny_r   <= '0;
      eat_r  <= 1'b0;
      ate_r  <= 1'b0;
      x_r    <= 1'b0;
      busy_r <= 1'b0;
      qhit_r <= 1'b0;
    end else begin
      qhit_r <= qhit;
      ate_r  <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.step &&
              (bus.state >= 3'd1) &&
              (bus.state <= 3'd4)) begin
            fsm    <= CALC;
            busy_r <= 1'b1;
          end
        end
        CALC: begin
          if (!dir_ok) begin
            fsm    <= IDLE;
            busy_r <= 1'b0;
          end else begin
            nx_r  <= nx;
            ny_r  <= ny;
            eat_r <= eat;
            if (oob) begin
              fsm <= DEAD;
              x_r <= 1'b1;
            end else begin
              idx <= '0;
              lim <= eat ? len : len - 5'd1;
              fsm <= CHECK;
            end
          end
        end
        CHECK: begin
          if (hit) begin
            fsm <= DEAD;
            x_r <= 1'b1;
          end else if (idx == lim - 5'd1) begin
            fsm   <= COMMIT;
            ate_r <= eat_r;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        COMMIT: begin
          for (int k = MAX_LEN - 1; k > 0; k--) begin
            seg_x[k] <= seg_x[k-1];
            seg_y[k] <= seg_y[k-1];
          end
          seg_x[0] <= nx_r;
          seg_y[0] <= ny_r;
          if (eat_r && (len < LMAX)) begin
            len <= len + 5'd1;
          end
          busy_r <= 1'b0;
          fsm    <= IDLE;
        end
        DEAD: begin
          fsm <= DEAD;
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end
endmodule
